// File: rtl/cfg_bus_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_bus_rr_arb
//  Description : Round-robin arbiter sharing one downstream cfg-bus slave
//                between NUM_REQ requesters. Requests are 1-cycle wr/rd
//                pulses, latched per requester and served one at a time. A
//                bounded wait forces an ack (rdata 32'hdead_beef) when the
//                slave stays silent.
//  Revision    : 1.0 - initial release
// ============================================================================
module cfg_bus_rr_arb #(
  parameter int NUM_REQ = 2,
  parameter int TIMEOUT = 256,
  parameter int GRANT_W = $clog2(NUM_REQ)
) (
  input  logic                   clk,
  input  logic                   sync_rst_n,
  input  logic                   flr,
  input  logic [NUM_REQ*32-1:0]  req_addr,
  input  logic [NUM_REQ*32-1:0]  req_wdata,
  input  logic [NUM_REQ-1:0]     req_wr,
  input  logic [NUM_REQ-1:0]     req_rd,
  output logic [NUM_REQ-1:0]     req_ack,
  output logic [NUM_REQ*32-1:0]  req_rdata,
  output logic [31:0]            ds_addr,
  output logic [31:0]            ds_wdata,
  output logic                   ds_wr,
  output logic                   ds_rd,
  input  logic                   ds_ack,
  input  logic [31:0]            ds_rdata,
  output logic                   busy,
  output logic [GRANT_W-1:0]     grant_id,
  output logic                   timeout_sticky,
  output logic [NUM_REQ-1:0]     ovf_sticky
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } state_t;

  localparam logic [31:0]        C_TIMEOUT_DATA = 32'hdead_beef;
  localparam logic [15:0]        C_TIMER_LAST   = 16'(TIMEOUT - 1);
  localparam logic [GRANT_W-1:0] C_LAST_INIT    = GRANT_W'(NUM_REQ - 1);

  state_t               r_state;
  logic [NUM_REQ-1:0]   r_pending;
  logic [31:0]          r_addr  [NUM_REQ];
  logic [31:0]          r_wdata [NUM_REQ];
  logic [NUM_REQ-1:0]   r_is_wr;
  logic [GRANT_W-1:0]   r_last_grant;
  logic [15:0]          r_timer;

  logic                 w_any;
  logic                 w_found_hi;
  logic                 w_found_lo;
  logic [GRANT_W-1:0]   w_pick_hi;
  logic [GRANT_W-1:0]   w_pick_lo;
  logic [GRANT_W-1:0]   w_pick;
  logic [NUM_REQ-1:0]   w_clear;
  logic                 w_done;
  logic [31:0]          w_resp_data;

  assign busy = (r_state != S_IDLE);

  // Round-robin pick: lowest pending index above the last grant, else the
  // lowest pending index overall (wrap). Also flags the slot being retired.
  always_comb begin
    w_any      = |r_pending;
    w_found_hi = 1'b0;
    w_found_lo = 1'b0;
    w_pick_hi  = '0;
    w_pick_lo  = '0;
    w_clear    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_clear[i] = (r_state == S_RESP) && (grant_id == GRANT_W'(i));
      if (r_pending[i]) begin
        if (!w_found_lo) begin
          w_found_lo = 1'b1;
          w_pick_lo  = GRANT_W'(i);
        end
        if (!w_found_hi && (GRANT_W'(i) > r_last_grant)) begin
          w_found_hi = 1'b1;
          w_pick_hi  = GRANT_W'(i);
        end
      end
    end
    w_pick = w_found_hi ? w_pick_hi : w_pick_lo;
  end

  // Completion condition in WAIT and the data returned to the requester.
  always_comb begin
    w_done      = (r_state == S_WAIT) && (ds_ack || (r_timer == C_TIMER_LAST));
    w_resp_data = ds_ack ? ds_rdata : C_TIMEOUT_DATA;
  end

  // Per-requester request capture; a pulse against a still-pending slot is
  // dropped and flagged, unless that slot is being retired this cycle.
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      r_pending  <= '0;
      r_is_wr    <= '0;
      ovf_sticky <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        r_addr[i]  <= '0;
        r_wdata[i] <= '0;
      end
    end else if (flr) begin
      r_pending <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_wr[i] || req_rd[i]) begin
          if (r_pending[i] && !w_clear[i]) begin
            ovf_sticky[i] <= 1'b1;
          end else begin
            r_pending[i] <= 1'b1;
            r_addr[i]    <= req_addr[32*i +: 32];
            r_wdata[i]   <= req_wdata[32*i +: 32];
            r_is_wr[i]   <= req_wr[i];
          end
        end else if (w_clear[i]) begin
          r_pending[i] <= 1'b0;
        end
      end
    end
  end

  // Transaction FSM with registered downstream and response outputs.
  always_ff @(posedge clk or negedge sync_rst_n) begin
    if (!sync_rst_n) begin
      r_state        <= S_IDLE;
      r_last_grant   <= C_LAST_INIT;
      r_timer        <= '0;
      grant_id       <= '0;
      ds_addr        <= '0;
      ds_wdata       <= '0;
      ds_wr          <= 1'b0;
      ds_rd          <= 1'b0;
      req_ack        <= '0;
      req_rdata      <= '0;
      timeout_sticky <= 1'b0;
    end else begin
      ds_wr   <= 1'b0;
      ds_rd   <= 1'b0;
      req_ack <= '0;
      if (flr) begin
        r_state <= S_IDLE;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_any) begin
              grant_id <= w_pick;
              ds_addr  <= r_addr[w_pick];
              ds_wdata <= r_wdata[w_pick];
              ds_wr    <= r_is_wr[w_pick];
              ds_rd    <= !r_is_wr[w_pick];
              r_state  <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            r_timer <= '0;
            r_state <= S_WAIT;
          end
          S_WAIT: begin
            if (w_done) begin
              for (int i = 0; i < NUM_REQ; i++) begin
                if (grant_id == GRANT_W'(i)) begin
                  req_ack[i]           <= 1'b1;
                  req_rdata[32*i +: 32] <= w_resp_data;
                end
              end
              if (!ds_ack) begin
                timeout_sticky <= 1'b1;
              end
              r_state <= S_RESP;
            end else if (r_timer != 16'hffff) begin
              r_timer <= r_timer + 16'd1;
            end
          end
          S_RESP: begin
            r_last_grant <= grant_id;
            r_state      <= S_IDLE;
          end
          default: begin
            r_state <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cfg_bus_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cfg_bus_rr_arb
//  Description : Scenario bench for cfg_bus_rr_arb with a scoreboard of
//                expected (requester, rdata) completions and a slave model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cfg_bus_rr_arb;

  localparam int NUM_REQ = 2;
  localparam int TIMEOUT = 20;
  localparam int GRANT_W = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  sync_rst_n;
  logic                  flr;
  logic [NUM_REQ*32-1:0] req_addr;
  logic [NUM_REQ*32-1:0] req_wdata;
  logic [NUM_REQ-1:0]    req_wr;
  logic [NUM_REQ-1:0]    req_rd;
  logic [NUM_REQ-1:0]    req_ack;
  logic [NUM_REQ*32-1:0] req_rdata;
  logic [31:0]           ds_addr;
  logic [31:0]           ds_wdata;
  logic                  ds_wr;
  logic                  ds_rd;
  logic                  ds_ack;
  logic [31:0]           ds_rdata;
  logic                  busy;
  logic [GRANT_W-1:0]    grant_id;
  logic                  timeout_sticky;
  logic [NUM_REQ-1:0]    ovf_sticky;

  int          vectors;
  int          miscompares;
  int          exp_id[$];
  logic [31:0] exp_data[$];
  logic [31:0] slv_data[$];
  bit          slv_en;
  int          slv_min;
  int          slv_max;
  int          ds_cnt;

  cfg_bus_rr_arb #(
    .NUM_REQ (NUM_REQ),
    .TIMEOUT (TIMEOUT),
    .GRANT_W (GRANT_W)
  ) dut (
    .clk            (clk),
    .sync_rst_n     (sync_rst_n),
    .flr            (flr),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wr         (req_wr),
    .req_rd         (req_rd),
    .req_ack        (req_ack),
    .req_rdata      (req_rdata),
    .ds_addr        (ds_addr),
    .ds_wdata       (ds_wdata),
    .ds_wr          (ds_wr),
    .ds_rd          (ds_rd),
    .ds_ack         (ds_ack),
    .ds_rdata       (ds_rdata),
    .busy           (busy),
    .grant_id       (grant_id),
    .timeout_sticky (timeout_sticky),
    .ovf_sticky     (ovf_sticky)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One-cycle request pulse; returns 1ns into the cycle after the pulse.
  task automatic pulse(input logic [1:0] wr, input logic [1:0] rd,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [31:0] w0, input logic [31:0] w1);
    step();
    req_wr    = wr;
    req_rd    = rd;
    req_addr  = {a1, a0};
    req_wdata = {w1, w0};
    step();
    req_wr = '0;
    req_rd = '0;
  endtask

  // Downstream slave: acks each pulse after a random delay when enabled.
  task automatic slave_model();
    int d;
    forever begin
      @(negedge clk);
      if (ds_wr || ds_rd) begin
        ds_cnt++;
        vectors++;
        if (ds_wr && ds_rd) begin
          miscompares++;
          $display("FAIL ds_pulse: wr=%0b rd=%0b, required exactly one high", ds_wr, ds_rd);
        end
        if (slv_en) begin
          d = $urandom_range(slv_max, slv_min);
          repeat (d) @(posedge clk);
          #1;
          ds_ack   = 1'b1;
          ds_rdata = (slv_data.size() != 0) ? slv_data.pop_front() : 32'h0;
          @(posedge clk);
          #1;
          ds_ack   = 1'b0;
          ds_rdata = 32'h0;
        end
      end
    end
  endtask

  // Scoreboard: every req_ack must match the oldest expected completion.
  task automatic monitor();
    int          id;
    int          want_id;
    logic [31:0] got;
    logic [31:0] want_d;
    forever begin
      @(negedge clk);
      if (req_ack !== 2'b00) begin
        vectors++;
        id  = req_ack[1] ? 1 : 0;
        got = req_rdata[32*id +: 32];
        if (req_ack === 2'b11 || $isunknown(req_ack)) begin
          miscompares++;
          $display("FAIL ack_onehot: req_ack=%b, required one-hot", req_ack);
        end else if (exp_id.size() == 0) begin
          miscompares++;
          $display("FAIL ack_unexpected: req_ack=%b rdata=%h, required no ack", req_ack, got);
        end else begin
          want_id = exp_id.pop_front();
          want_d  = exp_data.pop_front();
          if (id != want_id || got !== want_d) begin
            miscompares++;
            $display("FAIL ack_result: got id=%0d rdata=%h, required id=%0d rdata=%h",
                     id, got, want_id, want_d);
          end
        end
      end
    end
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    while ((exp_id.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 300) begin
      miscompares++;
      $display("FAIL %s_drain: %0d completions outstanding after %0d cycles, required 0",
               name, exp_id.size(), n);
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    logic [136:0] snap;
    #12;
    snap = {req_ack, req_rdata, ds_addr, ds_wdata, ds_wr, ds_rd, busy,
            grant_id, timeout_sticky, ovf_sticky};
    vectors++;
    if (snap !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h, required all zero", snap);
    end
    step();
    sync_rst_n = 1'b1;
    repeat (2) step();
  endtask

  task automatic test_simul_read(input logic [31:0] d0, input logic [31:0] d1);
    logic [31:0] seen[$];
    int n = 0;
    slv_en = 1; slv_min = 1; slv_max = 2;
    slv_data.push_back(d0); slv_data.push_back(d1);
    exp_id.push_back(0); exp_data.push_back(d0);
    exp_id.push_back(1); exp_data.push_back(d1);
    pulse(2'b00, 2'b11, 32'h200, 32'h300, 32'h0, 32'h0);
    while ((exp_id.size() != 0 || busy) && n < 300) begin
      @(negedge clk);
      n++;
      if (ds_rd) seen.push_back(ds_addr);
    end
    vectors++;
    if (n >= 300) begin
      miscompares++;
      $display("FAIL simul_drain: outstanding=%0d after %0d cycles, required 0", exp_id.size(), n);
    end
    vectors++;
    if (seen.size() != 2 || seen[0] !== 32'h200 || seen[1] !== 32'h300) begin
      miscompares++;
      $display("FAIL simul_order: %0d pulses, addrs %h %h, required 2 pulses 200 then 300",
               seen.size(), seen[0], seen[1]);
    end
    vectors++;
    if (req_rdata !== {d1, d0}) begin
      miscompares++;
      $display("FAIL simul_rdata: got %h, required %h", req_rdata, {d1, d0});
    end
  endtask

  task automatic test_round_robin();
    int issued = 2;
    int done   = 0;
    int guard  = 0;
    logic [1:0] acked;
    slv_en = 1; slv_min = 1; slv_max = 4;
    for (int n = 0; n < 20; n++) begin
      slv_data.push_back(32'h100 + n);
      exp_id.push_back(n % 2);
      exp_data.push_back(32'h100 + n);
    end
    pulse(2'b00, 2'b11, 32'h1000, 32'h2000, 32'h0, 32'h0);
    while (done < 20 && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (req_ack != 2'b00) begin
        done++;
        acked = req_ack;
        if (issued < 20) begin
          pulse(2'b00, acked, 32'h1000, 32'h2000, 32'h0, 32'h0);
          issued++;
        end
      end
    end
    vectors++;
    if (done != 20) begin
      miscompares++;
      $display("FAIL rr_count: got %0d acks, required 20", done);
    end
    wait_drain("rr");
  endtask

  task automatic test_single_write();
    slv_en = 1; slv_min = 1; slv_max = 1;
    slv_data.push_back(32'h5555_0000);
    exp_id.push_back(0); exp_data.push_back(32'h5555_0000);
    pulse(2'b01, 2'b00, 32'h0000_0104, 32'h0, 32'hA5A5_0001, 32'h0);
    @(negedge clk);  // t+1
    @(negedge clk);  // t+2
    vectors++;
    if ({ds_wr, ds_rd, busy, grant_id} !== 4'b1010 || ds_addr !== 32'h104 ||
        ds_wdata !== 32'hA5A5_0001) begin
      miscompares++;
      $display("FAIL wr_issue: wr/rd/busy/gnt=%b addr=%h wdata=%h, required 1010 104 a5a50001",
               {ds_wr, ds_rd, busy, grant_id}, ds_addr, ds_wdata);
    end
    @(negedge clk);  // t+3
    vectors++;
    if (ds_wr !== 1'b0 || busy !== 1'b1 || req_ack !== 2'b00) begin
      miscompares++;
      $display("FAIL wr_wait: ds_wr=%b busy=%b req_ack=%b, required 0 1 00", ds_wr, busy, req_ack);
    end
    @(negedge clk);  // t+4
    vectors++;
    if (req_ack !== 2'b01 || busy !== 1'b1 || ds_addr !== 32'h104 ||
        req_rdata[31:0] !== 32'h5555_0000) begin
      miscompares++;
      $display("FAIL wr_ack: req_ack=%b busy=%b addr=%h rdata=%h, required 01 1 104 55550000",
               req_ack, busy, ds_addr, req_rdata[31:0]);
    end
    @(negedge clk);  // t+5
    vectors++;
    if (req_ack !== 2'b00 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wr_done: req_ack=%b busy=%b, required 00 0", req_ack, busy);
    end
    wait_drain("wr");
  endtask

  task automatic test_timeout();
    int n = 0;
    int n_iss = -1;
    int n_ack = -1;
    vectors++;
    if (timeout_sticky !== 1'b0) begin
      miscompares++;
      $display("FAIL to_sticky_pre: got %b, required 0", timeout_sticky);
    end
    slv_en = 0;
    exp_id.push_back(1); exp_data.push_back(32'hDEAD_BEEF);
    pulse(2'b00, 2'b10, 32'h0, 32'h700, 32'h0, 32'h0);
    while (n_ack < 0 && n < 200) begin
      @(negedge clk);
      n++;
      if (ds_rd && n_iss < 0) n_iss = n;
      if (req_ack[1]) n_ack = n;
    end
    vectors++;
    if (n_ack < 0 || n_iss < 0 || (n_ack - n_iss) != TIMEOUT + 1) begin
      miscompares++;
      $display("FAIL to_latency: issue@%0d ack@%0d, required ack %0d cycles after issue",
               n_iss, n_ack, TIMEOUT + 1);
    end
    vectors++;
    if (timeout_sticky !== 1'b1) begin
      miscompares++;
      $display("FAIL to_sticky: got %b, required 1", timeout_sticky);
    end
    step();
    ds_ack = 1'b1; ds_rdata = 32'h77;
    step();
    ds_ack = 1'b0; ds_rdata = 32'h0;
    vectors++;
    if (req_rdata[63:32] !== 32'hDEAD_BEEF || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL to_late_ack: rdata1=%h busy=%b, required deadbeef 0", req_rdata[63:32], busy);
    end
    slv_en = 1; slv_min = 1; slv_max = 3;
    slv_data.push_back(32'h33);
    exp_id.push_back(0); exp_data.push_back(32'h33);
    pulse(2'b00, 2'b01, 32'h710, 32'h0, 32'h0, 32'h0);
    wait_drain("to_next");
  endtask

  task automatic test_overflow();
    int base;
    vectors++;
    if (ovf_sticky !== 2'b00) begin
      miscompares++;
      $display("FAIL ovf_pre: got %b, required 00", ovf_sticky);
    end
    slv_en = 1; slv_min = 3; slv_max = 3;
    slv_data.push_back(32'h44);
    exp_id.push_back(1); exp_data.push_back(32'h44);
    base = ds_cnt;
    pulse(2'b00, 2'b10, 32'h0, 32'h600, 32'h0, 32'h0);
    pulse(2'b00, 2'b10, 32'h0, 32'h6FF, 32'h0, 32'h0);
    pulse(2'b10, 2'b00, 32'h0, 32'h6FE, 32'h0, 32'h0);
    wait_drain("ovf");
    vectors++;
    if (ovf_sticky !== 2'b10 || (ds_cnt - base) != 1 || ds_addr !== 32'h600) begin
      miscompares++;
      $display("FAIL ovf_result: ovf=%b pulses=%0d addr=%h, required 10 1 600",
               ovf_sticky, ds_cnt - base, ds_addr);
    end
  endtask

  task automatic test_flr();
    int base;
    slv_en = 0;
    base = ds_cnt;
    pulse(2'b00, 2'b01, 32'h800, 32'h0, 32'h0, 32'h0);
    step();          // t+2 ISSUE
    step();          // t+3 WAIT
    flr = 1'b1;
    step();
    flr = 1'b0;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || req_ack !== 2'b00) begin
      miscompares++;
      $display("FAIL flr_idle: busy=%b req_ack=%b, required 0 00", busy, req_ack);
    end
    repeat (10) @(negedge clk);
    vectors++;
    if ((ds_cnt - base) != 1) begin
      miscompares++;
      $display("FAIL flr_pending: %0d pulses, required 1", ds_cnt - base);
    end
    vectors++;
    if (timeout_sticky !== 1'b1 || ovf_sticky !== 2'b10 || grant_id !== 1'b0 ||
        req_rdata !== {32'h44, 32'h33}) begin
      miscompares++;
      $display("FAIL flr_retain: to=%b ovf=%b gnt=%b rdata=%h, required 1 10 0 0000004400000033",
               timeout_sticky, ovf_sticky, grant_id, req_rdata);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    logic [136:0] snap;
    slv_en = 0;
    base = ds_cnt;
    pulse(2'b00, 2'b10, 32'h0, 32'h900, 32'h0, 32'h0);
    step();
    step();          // in WAIT
    sync_rst_n = 1'b0;
    #1;
    snap = {req_ack, req_rdata, ds_addr, ds_wdata, ds_wr, ds_rd, busy,
            grant_id, timeout_sticky, ovf_sticky};
    vectors++;
    if (snap !== '0) begin
      miscompares++;
      $display("FAIL rst_mid: got %h, required all zero", snap);
    end
    step();
    step();
    sync_rst_n = 1'b1;
    repeat (8) @(negedge clk);
    vectors++;
    if ((ds_cnt - base) != 1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_mid_after: pulses=%0d busy=%b, required 1 0", ds_cnt - base, busy);
    end
  endtask

  initial begin
    sync_rst_n = 1'b0;
    flr        = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wr     = '0;
    req_rd     = '0;
    ds_ack     = 1'b0;
    ds_rdata   = 32'h0;
    vectors    = 0;
    miscompares = 0;
    slv_en     = 1;
    slv_min    = 1;
    slv_max    = 1;
    ds_cnt     = 0;
    fork
      slave_model();
      monitor();
    join_none
    test_reset();
    test_simul_read(32'h11, 32'h22);
    test_round_robin();
    test_single_write();
    test_timeout();
    test_overflow();
    test_flr();
    test_reset_mid();
    test_simul_read(32'hA1, 32'hA2);
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
